em_banked_memory: RTL

Parametrised successor to the byte-addressed external memory. It provides a single request/response data port: byte, half or word, with 1-cycle registered read latency. It also has a combinational 16-bit instruction pre-fetch port with same-cycle store forwarding, and the switch/LED/seven-segment memory-mapped I/O window. Unlike its predecessor, it zero-fills the whole array after reset with a sequential clear engine, and it reports out-of-range accesses as faults.

---
 rtl/em_banked_memory.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/em_banked_memory.sv
// Byte-addressed memory with a registered request/response port, a 16-bit fetch port
// with store forwarding, a switch/LED/seven-segment I/O window and a post-reset clear engine.
module em_banked_memory #(
    parameter int MEM_BYTES = 16384,
    parameter int IO_BASE   = 8192,
    parameter int CLR_BYTES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    input  logic [31:0] fetch_addr,
    output logic [15:0] fetch_data,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [31:0] sseg,
    output logic        init_busy
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [15:0] FETCH_IDLE = 16'hE800;
    localparam logic [AW-1:0] SSEG_0 = AW'(IO_BASE + 1);
    localparam logic [AW-1:0] SSEG_1 = AW'(IO_BASE + 2);
    localparam logic [AW-1:0] SSEG_2 = AW'(IO_BASE + 3);
    localparam logic [AW-1:0] SSEG_3 = AW'(IO_BASE + 4);
    localparam logic [AW-1:0] SW_HI  = AW'(IO_BASE + 5);
    localparam logic [AW-1:0] SW_LO  = AW'(IO_BASE + 6);
    localparam logic [AW-1:0] LED_HI = AW'(IO_BASE + 7);
    localparam logic [AW-1:0] LED_LO = AW'(IO_BASE + 8);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e               state_q, state_d;
    logic [31:0]          clrPtr_q, clrPtr_d;
    logic                 rspValid_q, rspValid_d;
    logic                 rspFault_q, rspFault_d;
    logic [31:0]          rspData_q, rspData_d;
    logic [7:0]           mem_q [MEM_BYTES];

    logic                 accept, storeAcc, storeOk, reqInRange;
    logic [2:0]           reqBytes;
    logic [32:0]          reqLast;
    logic [AW-1:0]        byteIdx [4];
    logic [3:0]           byteOn;
    logic [31:0]          rdWord;
    logic [31:0]          clrAddr [CLR_BYTES];
    logic [CLR_BYTES-1:0] clrOn;
    logic                 fetchOk;
    logic [32:0]          fetchA [2];
    logic [32:0]          fetchOff [2];
    logic [7:0]           fetchByte [2];

    // Request decode: range check is done 33 bits wide so addresses near 2^32 cannot wrap.
    always_comb begin
        accept = req_valid && (state_q == RUN);
        case (req_size)
            2'd0:    reqBytes = 3'd1;
            2'd1:    reqBytes = 3'd2;
            default: reqBytes = 3'd4;
        endcase
        reqLast    = {1'b0, req_addr} + {30'b0, reqBytes} - 33'd1;
        reqInRange = !req_addr[31] && (reqLast < MEM_LIMIT);
        storeAcc   = accept && req_write;
        storeOk    = storeAcc && reqInRange;
        rdWord     = '0;
        for (int k = 0; k < 4; k++) begin
            byteIdx[k] = req_addr[AW-1:0] + AW'(k);
            byteOn[k]  = 3'(k) < reqBytes;
            if (byteOn[k]) rdWord[8*k +: 8] = mem_q[byteIdx[k]];
        end
        for (int k = 0; k < CLR_BYTES; k++) begin
            clrAddr[k] = clrPtr_q + 32'(k);
            clrOn[k]   = clrAddr[k] < 32'(MEM_BYTES);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= CLEAR;
            clrPtr_q   <= '0;
            rspValid_q <= 1'b0;
            rspFault_q <= 1'b0;
            rspData_q  <= '0;
        end else begin
            state_q    <= state_d;
            clrPtr_q   <= clrPtr_d;
            rspValid_q <= rspValid_d;
            rspFault_q <= rspFault_d;
            rspData_q  <= rspData_d;
        end
    end

    // Clear engine walks the array once, then every accepted request yields one response.
    always_comb begin
        state_d    = state_q;
        clrPtr_d   = clrPtr_q;
        rspValid_d = 1'b0;
        rspFault_d = 1'b0;
        rspData_d  = '0;
        case (state_q)
            CLEAR: begin
                clrPtr_d = clrPtr_q + 32'(CLR_BYTES);
                if (clrPtr_d >= 32'(MEM_BYTES)) state_d = RUN;
            end
            RUN: begin
                rspValid_d = accept;
                rspFault_d = accept && !reqInRange;
                if (accept && !req_write && reqInRange) rspData_d = rdWord;
            end
        endcase
    end

    // Switch bytes are refreshed only in cycles without an accepted store, so stores never race them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                for (int k = 0; k < CLR_BYTES; k++) begin
                    if (clrOn[k]) mem_q[clrAddr[k][AW-1:0]] <= '0;
                end
            end else begin
                if (!storeAcc) begin
                    mem_q[SW_HI] <= sw[15:8];
                    mem_q[SW_LO] <= sw[7:0];
                end
                if (storeOk) begin
                    for (int k = 0; k < 4; k++) begin
                        if (byteOn[k]) mem_q[byteIdx[k]] <= req_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // Each fetched byte independently takes the in-flight store data when that store covers it.
    always_comb begin
        fetchOk = !fetch_addr[31] && (({1'b0, fetch_addr} + 33'd1) < MEM_LIMIT);
        for (int k = 0; k < 2; k++) begin
            fetchA[k]   = {1'b0, fetch_addr} + 33'(k);
            fetchOff[k] = fetchA[k] - {1'b0, req_addr};
            if (storeOk && (fetchA[k] >= {1'b0, req_addr}) && (fetchOff[k] < {30'b0, reqBytes}))
                fetchByte[k] = req_wdata[{fetchOff[k][1:0], 3'b000} +: 8];
            else
                fetchByte[k] = mem_q[fetchA[k][AW-1:0]];
        end
    end

    always_comb begin
        led        = '0;
        sseg       = '0;
        fetch_data = FETCH_IDLE;
        if (state_q == RUN) begin
            led  = {mem_q[LED_HI], mem_q[LED_LO]};
            sseg = {mem_q[SSEG_0], mem_q[SSEG_1], mem_q[SSEG_2], mem_q[SSEG_3]};
            if (fetchOk) fetch_data = {fetchByte[1], fetchByte[0]};
        end
    end

    assign req_ready = (state_q == RUN);
    assign init_busy = (state_q == CLEAR);
    assign rsp_valid = rspValid_q;
    assign rsp_fault = rspFault_q;
    assign rsp_data  = rspData_q;

endmodule
